// File: rtl/ysyx_pkg.sv
// Shared types and constants for the ysyx instruction fetch path.
package ysyx_pkg;
  localparam int               XLEN         = 32;
  localparam logic [XLEN-1:0]  RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0]  NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;
endpackage

// File: rtl/ysyx_ifu_pcgen.sv
// PC register with next-pc selection: reset, redirect, sequential advance, or hold.
module ysyx_ifu_pcgen
  import ysyx_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            adv_i,
  output logic [XLEN-1:0] pc_o
);
  logic [XLEN-1:0] pc_q, pc_d;

  // Redirect beats sequential advance; +4 wraps silently at 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) pc_d = redirect_pc_i;
    else if (adv_i)       pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding imem request, registered handoff to decode,
// redirect support with stale-response dropping.
module ysyx_ifu
  import ysyx_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err
);
  ifu_state_e      state_q;
  logic            drop_q, vld_q, err_q;
  logic [XLEN-1:0] pc, inst_q, ipc_q;
  logic            pc_adv;

  assign pc_adv = (state_q == S_HOLD) & inst_ready;

  ysyx_ifu_pcgen #(.RESET_PC(RESET_PC)) u_pcgen (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .adv_i            (pc_adv),
    .pc_o             (pc)
  );

  // While a stale response is still owed, hold off so only one request is ever in flight.
  assign imem_req_valid = (state_q == S_REQ) & ~drop_q & ~rst & (pc[1:0] == 2'b00);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      if (state_q == S_WAIT)   drop_q <= ~imem_rsp_valid;
      else if (imem_rsp_valid) drop_q <= 1'b0;
      vld_q   <= 1'b0;
      inst_q  <= NOP_INST;
      ipc_q   <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (drop_q) begin
            if (imem_rsp_valid) drop_q <= 1'b0;
          end else if (pc[1:0] != 2'b00) begin
            if (!redirect_valid) begin
              state_q <= S_HOLD;
              vld_q   <= 1'b1;
              err_q   <= 1'b1;
              inst_q  <= NOP_INST;
              ipc_q   <= pc;
            end
          end else if (imem_req_ready) begin
            state_q <= S_WAIT;
            drop_q  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q || redirect_valid) begin
              state_q <= S_REQ;
              drop_q  <= 1'b0;
            end else begin
              state_q <= S_HOLD;
              vld_q   <= 1'b1;
              inst_q  <= imem_rsp_data;
              ipc_q   <= pc;
              err_q   <= imem_rsp_err;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) begin
            state_q <= S_REQ;
            vld_q   <= 1'b0;
            inst_q  <= NOP_INST;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign inst_valid = vld_q;
  assign inst       = inst_q;
  assign inst_pc    = ipc_q;
  assign inst_err   = err_q;
endmodule
